// File: rtl/io_port_bank.sv
// io_port_bank: memory-mapped IO block for the FemtoRV32 SoC bus.
//
// NUM_PORTS output ports of WIDTH bits each. Every port can be accessed
// through four aliases: write (OUT), set (SET), clear (CLR) and toggle (TGL).
// Writes honour byte-lane masking. There is also one synchronised input port
// with rising/falling edge detection, sticky write-1-to-clear status, and a
// level interrupt. Read data is registered, so reads have one cycle of latency.
//
// Ports:
//   clk       system clock
//   reset     asynchronous active-high reset
//   sel       IO region select (mem_address_is_io)
//   addr      IO word address
//   wmask     byte write mask, nonzero means write
//   wdata     write data
//   rstrb     read strobe
//   rdata     registered read data
//   port_out  output ports, port k at [k*WIDTH +: WIDTH]
//   port_in   asynchronous input pins
//   irq       interrupt request, registered OR of STATUS
module io_port_bank #(
    parameter int unsigned      NUM_PORTS   = 2,
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      IN_WIDTH    = 8,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sel,
    input  logic [7:0]                 addr,
    input  logic [3:0]                 wmask,
    input  logic [31:0]                wdata,
    input  logic                       rstrb,
    output logic [31:0]                rdata,
    output logic [NUM_PORTS*WIDTH-1:0] port_out,
    input  logic [IN_WIDTH-1:0]        port_in,
    output logic                       irq
);

    // Address bits [5:4] select the access alias inside the port region.
    typedef enum logic [1:0] {
        GRP_OUT = 2'd0,
        GRP_SET = 2'd1,
        GRP_CLR = 2'd2,
        GRP_TGL = 2'd3
    } grp_e;

    localparam logic [7:0] ADDR_IN      = 8'h40;
    localparam logic [7:0] ADDR_RISE_EN = 8'h41;
    localparam logic [7:0] ADDR_FALL_EN = 8'h42;
    localparam logic [7:0] ADDR_STATUS  = 8'h43;

    logic              wr_en;
    logic              rd_en;
    logic [31:0]       lane_mask;
    logic [31:0]       operand;
    logic              port_region;
    logic [3:0]        port_idx;
    grp_e              grp;

    logic [WIDTH-1:0]  out_q [NUM_PORTS];
    logic [WIDTH-1:0]  out_d [NUM_PORTS];

    logic [IN_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [IN_WIDTH-1:0] in_val;
    logic [IN_WIDTH-1:0] prev_q;
    logic [IN_WIDTH-1:0] rise_en_q;
    logic [IN_WIDTH-1:0] fall_en_q;
    logic [IN_WIDTH-1:0] status_q;
    logic [IN_WIDTH-1:0] status_set;
    logic [IN_WIDTH-1:0] status_clr;
    logic [IN_WIDTH-1:0] status_d;

    logic [31:0]       rd_val;

    // Data bits above WIDTH/IN_WIDTH are dropped on purpose.
    logic unused_bits;
    assign unused_bits = ^{operand, lane_mask};

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    always_comb begin
        wr_en       = sel && (wmask != 4'b0000);
        rd_en       = sel && rstrb;
        lane_mask   = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
        operand     = wdata & lane_mask;
        port_region = (addr[7:6] == 2'b00);
        port_idx    = addr[3:0];
        grp         = grp_e'(addr[5:4]);
    end

    // ------------------------------------------------------------------
    // Output ports
    // ------------------------------------------------------------------
    always_comb begin
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            out_d[k] = out_q[k];
            if (wr_en && port_region && (port_idx == 4'(k))) begin
                case (grp)
                    // Unmasked lanes keep their previous contents.
                    GRP_OUT: out_d[k] = (out_q[k] & ~lane_mask[WIDTH-1:0]) | operand[WIDTH-1:0];
                    GRP_SET: out_d[k] = out_q[k] | operand[WIDTH-1:0];
                    GRP_CLR: out_d[k] = out_q[k] & ~operand[WIDTH-1:0];
                    GRP_TGL: out_d[k] = out_q[k] ^ operand[WIDTH-1:0];
                    default: out_d[k] = out_q[k];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                out_q[k] <= RESET_VALUE;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                out_q[k] <= out_d[k];
            end
        end
    end

    always_comb begin
        port_out = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            port_out[k*WIDTH +: WIDTH] = out_q[k];
        end
    end

    // ------------------------------------------------------------------
    // Input path: synchroniser, edge detect, sticky status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= port_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= in_val;
        end
    end

    assign in_val = sync_q[SYNC_STAGES-1];

    // Enables are sampled before any same-cycle write, so a newly written
    // enable only affects edges seen from the next cycle onwards.
    always_comb begin
        status_set = ((in_val & ~prev_q) & rise_en_q) | ((~in_val & prev_q) & fall_en_q);
        status_clr = '0;
        if (wr_en && (addr == ADDR_STATUS)) begin
            status_clr = operand[IN_WIDTH-1:0];
        end
        // Set is applied after clear so a coincident edge wins.
        status_d = (status_q & ~status_clr) | status_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            irq       <= 1'b0;
        end else begin
            if (wr_en && (addr == ADDR_RISE_EN)) begin
                rise_en_q <= operand[IN_WIDTH-1:0];
            end
            if (wr_en && (addr == ADDR_FALL_EN)) begin
                fall_en_q <= operand[IN_WIDTH-1:0];
            end
            status_q <= status_d;
            irq      <= |status_q;
        end
    end

    // ------------------------------------------------------------------
    // Read path: mux uses pre-write state, result registered on rd_en
    // ------------------------------------------------------------------
    always_comb begin
        rd_val = '0;
        if (port_region) begin
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                if (port_idx == 4'(k)) begin
                    rd_val[WIDTH-1:0] = out_q[k];
                end
            end
        end else begin
            case (addr)
                ADDR_IN:      rd_val[IN_WIDTH-1:0] = in_val;
                ADDR_RISE_EN: rd_val[IN_WIDTH-1:0] = rise_en_q;
                ADDR_FALL_EN: rd_val[IN_WIDTH-1:0] = fall_en_q;
                ADDR_STATUS:  rd_val[IN_WIDTH-1:0] = status_q;
                default:      rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= rd_val;
        end
    end

endmodule

// File: tb/tb_io_port_bank.sv
module tb_io_port_bank;

    localparam int NP = 2;
    localparam int SS = 2;
    localparam logic [7:0] RV = 8'hA5;

    logic        clk;
    logic        reset;
    logic        sel;
    logic [7:0]  addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic        rstrb;
    logic [31:0] rdata;
    logic [15:0] port_out;
    logic [7:0]  port_in;
    logic        irq;

    io_port_bank #(
        .NUM_PORTS  (NP),
        .WIDTH      (8),
        .IN_WIDTH   (8),
        .SYNC_STAGES(SS),
        .RESET_VALUE(RV)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sel     (sel),
        .addr    (addr),
        .wmask   (wmask),
        .wdata   (wdata),
        .rstrb   (rstrb),
        .rdata   (rdata),
        .port_out(port_out),
        .port_in (port_in),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference model: architectural state plus a history of sampled pins.
    logic [7:0]  m_out [NP];
    logic [7:0]  m_rise, m_fall, m_status;
    logic        m_irq;
    logic [31:0] m_rdata;
    logic [7:0]  hist [SS+1];   // hist[0] = pin value at most recent edge

    task automatic model_reset();
        for (int k = 0; k < NP; k++) m_out[k] = RV;
        m_rise = '0; m_fall = '0; m_status = '0; m_irq = 1'b0; m_rdata = '0;
        for (int i = 0; i <= SS; i++) hist[i] = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a);
        int k;
        k = int'(a & 8'h0F);
        if (a < 8'h40) return (k < NP) ? {24'h0, m_out[k]} : 32'h0;
        case (a)
            8'h40:   return {24'h0, hist[SS-1]};
            8'h41:   return {24'h0, m_rise};
            8'h42:   return {24'h0, m_fall};
            8'h43:   return {24'h0, m_status};
            default: return 32'h0;
        endcase
    endfunction

    // Advance one clock with the currently driven inputs, update the model
    // and compare all visible outputs.
    task automatic step();
        logic [31:0] lm, op;
        logic [7:0]  n_out [NP];
        logic [7:0]  n_rise, n_fall, w1c, cur_in, cur_prev, edges_set, pin;
        logic [31:0] n_rdata;
        int k;
        lm = '0;
        for (int b = 0; b < 4; b++) if (wmask[b]) lm = lm | (32'hFF << (8 * b));
        op = wdata & lm;
        for (int j = 0; j < NP; j++) n_out[j] = m_out[j];
        n_rise = m_rise; n_fall = m_fall; w1c = '0;
        n_rdata = (sel && rstrb) ? model_read(addr) : m_rdata;
        if (sel && wmask != 4'b0000) begin
            k = int'(addr & 8'h0F);
            if (addr < 8'h40) begin
                if (k < NP) begin
                    case (int'(addr) / 16)
                        0: n_out[k] = (m_out[k] & ~lm[7:0]) | op[7:0];
                        1: n_out[k] = m_out[k] | op[7:0];
                        2: n_out[k] = m_out[k] & ~op[7:0];
                        default: n_out[k] = m_out[k] ^ op[7:0];
                    endcase
                end
            end else if (addr == 8'h41) n_rise = op[7:0];
            else if (addr == 8'h42) n_fall = op[7:0];
            else if (addr == 8'h43) w1c = op[7:0];
        end
        cur_in   = hist[SS-1];
        cur_prev = hist[SS];
        edges_set = (cur_in & ~cur_prev & m_rise) | (~cur_in & cur_prev & m_fall);
        pin = port_in;

        @(posedge clk);
        #1;

        m_irq = (m_status != 0);
        m_status = (m_status & ~w1c) | edges_set;
        for (int j = 0; j < NP; j++) m_out[j] = n_out[j];
        m_rise = n_rise; m_fall = n_fall; m_rdata = n_rdata;
        for (int i = SS; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = pin;

        check_eq("port_out", {16'h0, port_out}, {16'h0, m_out[1], m_out[0]});
        check_eq("rdata", rdata, m_rdata);
        check_eq("irq", {31'h0, irq}, {31'h0, m_irq});
    endtask

    task automatic bus(input logic s, input logic [7:0] a, input logic [3:0] m,
                       input logic [31:0] d, input logic r);
        sel = s; addr = a; wmask = m; wdata = d; rstrb = r;
        step();
        sel = 1'b0; wmask = 4'b0000; rstrb = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset = 1'b1; sel = 1'b0; addr = '0; wmask = '0; wdata = '0; rstrb = 1'b0; port_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_port_out", {16'h0, port_out}, 32'h0000_A5A5);
        check_eq("reset_irq", {31'h0, irq}, 32'h0);
        check_eq("reset_rdata", rdata, 32'h0);
        reset = 1'b0;
        idle(2);

        // Output port aliases
        bus(1'b1, 8'h01, 4'b0001, 32'h0000_003C, 1'b0);
        check_eq("out1_write", {24'h0, port_out[15:8]}, 32'h3C);
        bus(1'b1, 8'h11, 4'b0001, 32'h01, 1'b0);
        check_eq("out1_set", {24'h0, port_out[15:8]}, 32'h3D);
        bus(1'b1, 8'h21, 4'b0001, 32'h0C, 1'b0);
        check_eq("out1_clr", {24'h0, port_out[15:8]}, 32'h31);
        bus(1'b1, 8'h31, 4'b0001, 32'hFF, 1'b0);
        check_eq("out1_tgl", {24'h0, port_out[15:8]}, 32'hCE);
        bus(1'b1, 8'h01, 4'b0000, 32'h0, 1'b1);
        check_eq("out1_read", rdata, 32'h0000_00CE);

        // Masking and unmapped addresses
        bus(1'b1, 8'h00, 4'b0000, 32'h12, 1'b0);
        check_eq("zero_mask", {16'h0, port_out}, 32'h0000_CEA5);
        bus(1'b1, 8'h00, 4'b1110, 32'hFFFF_FF12, 1'b0);
        check_eq("lane_mask", {16'h0, port_out}, 32'h0000_CEA5);
        bus(1'b1, 8'h05, 4'b1111, 32'hFFFF_FFFF, 1'b0);
        check_eq("oob_write", {16'h0, port_out}, 32'h0000_CEA5);
        bus(1'b1, 8'h05, 4'b0000, 32'h0, 1'b1);
        check_eq("oob_read", rdata, 32'h0);
        bus(1'b1, 8'h7F, 4'b0000, 32'h0, 1'b1);
        check_eq("unmapped_read", rdata, 32'h0);

        // Rising edge with enable
        bus(1'b1, 8'h41, 4'b0001, 32'h01, 1'b0);
        port_in = 8'h01;
        idle(2);
        bus(1'b1, 8'h43, 4'b0000, 32'h0, 1'b1);
        check_eq("status_before", rdata, 32'h0);
        check_eq("irq_before", {31'h0, irq}, 32'h0);
        bus(1'b1, 8'h43, 4'b0000, 32'h0, 1'b1);
        check_eq("status_rise", rdata, 32'h01);
        check_eq("irq_rise", {31'h0, irq}, 32'h1);

        // Rising edge on bit 1 with only FALL_EN set
        bus(1'b1, 8'h42, 4'b0001, 32'h02, 1'b0);
        port_in = 8'h03;
        idle(4);
        bus(1'b1, 8'h43, 4'b0000, 32'h0, 1'b1);
        check_eq("status_rise_disabled", rdata, 32'h01);

        // Set wins over simultaneous W1C
        port_in = 8'h02;
        idle(3);
        port_in = 8'h03;
        idle(2);
        bus(1'b1, 8'h43, 4'b0001, 32'h01, 1'b0);
        bus(1'b1, 8'h43, 4'b0000, 32'h0, 1'b1);
        check_eq("status_set_wins", rdata, 32'h01);
        check_eq("irq_set_wins", {31'h0, irq}, 32'h1);
        bus(1'b1, 8'h43, 4'b0001, 32'h01, 1'b0);
        check_eq("irq_lag", {31'h0, irq}, 32'h1);
        bus(1'b1, 8'h43, 4'b0000, 32'h0, 1'b1);
        check_eq("status_cleared", rdata, 32'h0);
        check_eq("irq_cleared", {31'h0, irq}, 32'h0);

        // Randomised traffic against the model
        for (int n = 0; n < 800; n++) begin
            logic [7:0] a;
            case ($urandom_range(0, 3))
                0, 1: a = 8'($urandom_range(0, 3) * 16 + $urandom_range(0, 2));
                2:    a = 8'(8'h40 + $urandom_range(0, 3));
                default: a = 8'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0) port_in = 8'($urandom);
            bus(1'($urandom_range(0, 4) != 0), a,
                ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom),
                $urandom, 1'($urandom));
        end

        // Reset in the middle of a read and a write
        bus(1'b1, 8'h41, 4'b0001, 32'hFF, 1'b0);
        port_in = 8'h00;
        idle(3);
        port_in = 8'hFF;
        idle(4);
        bus(1'b1, 8'h01, 4'b0001, 32'h77, 1'b1);
        check_eq("pre_reset_irq", {31'h0, irq}, 32'h1);
        sel = 1'b1; addr = 8'h01; wmask = 4'b0001; wdata = 32'h5A; rstrb = 1'b1;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_eq("async_port_out", {16'h0, port_out}, 32'h0000_A5A5);
        check_eq("async_rdata", rdata, 32'h0);
        check_eq("async_irq", {31'h0, irq}, 32'h0);
        sel = 1'b0; wmask = 4'b0000; rstrb = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(4);
        bus(1'b1, 8'h43, 4'b0000, 32'h0, 1'b1);
        check_eq("post_reset_status", rdata, 32'h0);
        bus(1'b1, 8'h41, 4'b0000, 32'h0, 1'b1);
        check_eq("post_reset_rise_en", rdata, 32'h0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
